// File: rtl/pztb_pkg.sv
// Shared types and helpers for the pztb memory traffic generator and its checker.
package pztb_pkg;

  localparam int PZTB_MEM_TRAFFIC_ERROR_WIDTH = 16;
  localparam int PZTB_PATTERN_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } pztb_mem_traffic_state;

  // Callers zero-extend seed and address to 64 bits and truncate the sum to their data width.
  function automatic logic [PZTB_PATTERN_WIDTH-1:0] pztb_mem_pattern(
    input logic [PZTB_PATTERN_WIDTH-1:0] seed,
    input logic [PZTB_PATTERN_WIDTH-1:0] address
  );
    return seed + address;
  endfunction

endpackage

// File: rtl/pztb_mem_traffic_checker.sv
// In-order read-response checker: tracks the expected address, compares data, counts mismatches.
// PZTB_MEM_TRAFFIC_FIRST_ERROR_EN adds capture of the first mismatch of each sweep.
module pztb_mem_traffic_checker
  import pztb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [ADDRESS_WIDTH-1:0]                base_address,
  input  logic [DATA_WIDTH-1:0]                   seed,
  input  logic                                    resp_fire,
  input  logic                                    spurious,
  input  logic [DATA_WIDTH-1:0]                   resp_data,
  output logic [PZTB_MEM_TRAFFIC_ERROR_WIDTH-1:0] error_count
`ifdef PZTB_MEM_TRAFFIC_FIRST_ERROR_EN
  ,
  output logic                                    first_error_valid,
  output logic [ADDRESS_WIDTH-1:0]                first_error_address,
  output logic [DATA_WIDTH-1:0]                   first_error_data
`endif
);

  logic [ADDRESS_WIDTH-1:0] resp_address;
  logic [DATA_WIDTH-1:0]    expected;
  logic                     mismatch;

  assign expected = DATA_WIDTH'(pztb_mem_pattern(PZTB_PATTERN_WIDTH'(seed),
                                                 PZTB_PATTERN_WIDTH'(resp_address)));

  // Case inequality so that X/Z on the response bus is reported as a mismatch.
  assign mismatch = resp_fire && (spurious || (resp_data !== expected));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_address <= '0;
      error_count  <= '0;
    end else if (start) begin
      resp_address <= base_address;
      error_count  <= '0;
    end else begin
      if (resp_fire && !spurious) begin
        resp_address <= resp_address + ADDRESS_WIDTH'(1);
      end
      if (mismatch && (error_count != '1)) begin
        error_count <= error_count + PZTB_MEM_TRAFFIC_ERROR_WIDTH'(1);
      end
    end
  end

`ifdef PZTB_MEM_TRAFFIC_FIRST_ERROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_error_valid   <= 1'b0;
      first_error_address <= '0;
      first_error_data    <= '0;
    end else if (start) begin
      first_error_valid   <= 1'b0;
      first_error_address <= '0;
      first_error_data    <= '0;
    end else if (mismatch && !first_error_valid) begin
      first_error_valid   <= 1'b1;
      first_error_address <= resp_address;
      first_error_data    <= resp_data;
    end
  end
`endif

endmodule

// File: rtl/pztb_mem_traffic_gen.sv
// Memory traffic generator: write-then-read-back sweep with in-order response checking.
// Define PZTB_MEM_TRAFFIC_FIRST_ERROR_EN to expose the first-mismatch capture ports.
module pztb_mem_traffic_gen
  import pztb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_start,
  input  logic [ADDRESS_WIDTH-1:0]                i_base_address,
  input  logic [ADDRESS_WIDTH:0]                  i_word_count,
  input  logic [DATA_WIDTH-1:0]                   i_seed,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic [PZTB_MEM_TRAFFIC_ERROR_WIDTH-1:0] o_error_count,
  output logic                                    o_req_valid,
  input  logic                                    i_req_ready,
  output logic                                    o_req_write,
  output logic [ADDRESS_WIDTH-1:0]                o_req_address,
  output logic [DATA_WIDTH-1:0]                   o_req_data,
  input  logic                                    i_resp_valid,
  output logic                                    o_resp_ready,
  input  logic [DATA_WIDTH-1:0]                   i_resp_data
`ifdef PZTB_MEM_TRAFFIC_FIRST_ERROR_EN
  ,
  output logic                                    o_first_error_valid,
  output logic [ADDRESS_WIDTH-1:0]                o_first_error_address,
  output logic [DATA_WIDTH-1:0]                   o_first_error_data
`endif
);

  localparam int COUNT_WIDTH = ADDRESS_WIDTH + 1;
  localparam int OUT_WIDTH   = $clog2(MAX_OUTSTANDING + 1);

  pztb_mem_traffic_state state, next_state;

  logic [ADDRESS_WIDTH-1:0] base, address;
  logic [COUNT_WIDTH-1:0]   count, remaining;
  logic [DATA_WIDTH-1:0]    seed;
  logic [OUT_WIDTH-1:0]     outstanding;
  logic start_accept, req_fire, read_fire, resp_fire, spurious, resp_retire, last_req, at_limit;

  assign start_accept = (state == IDLE) && i_start;
  assign req_fire     = o_req_valid && i_req_ready;
  assign read_fire    = req_fire && !o_req_write;
  assign resp_fire    = i_resp_valid && o_resp_ready;
  assign spurious     = resp_fire && (outstanding == '0);
  assign resp_retire  = resp_fire && !spurious;
  assign last_req     = (remaining == COUNT_WIDTH'(1));
  assign at_limit     = (outstanding == OUT_WIDTH'(MAX_OUTSTANDING));

  assign o_busy        = (state != IDLE);
  assign o_resp_ready  = o_busy;
  assign o_done        = (state == DONE);
  assign o_req_address = address;
  assign o_req_data    = o_req_write
                       ? DATA_WIDTH'(pztb_mem_pattern(PZTB_PATTERN_WIDTH'(seed),
                                                      PZTB_PATTERN_WIDTH'(address)))
                       : '0;

  // Reads are gated purely by the registered outstanding count, so a presented read can never be withdrawn.
  always_comb begin
    next_state  = state;
    o_req_valid = 1'b0;
    o_req_write = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state = (i_word_count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        o_req_valid = 1'b1;
        o_req_write = 1'b1;
        if (i_req_ready && last_req) begin
          next_state = READ;
        end
      end
      READ: begin
        o_req_valid = !at_limit;
        if (!at_limit && i_req_ready && last_req) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The address and remaining count rewind to the sweep start after the last write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base      <= '0;
      address   <= '0;
      count     <= '0;
      remaining <= '0;
      seed      <= '0;
    end else if (start_accept) begin
      base      <= i_base_address;
      address   <= i_base_address;
      count     <= i_word_count;
      remaining <= i_word_count;
      seed      <= i_seed;
    end else if (req_fire) begin
      if (last_req) begin
        address   <= base;
        remaining <= count;
      end else begin
        address   <= address + ADDRESS_WIDTH'(1);
        remaining <= remaining - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding <= '0;
    end else if (read_fire && !resp_retire) begin
      outstanding <= outstanding + OUT_WIDTH'(1);
    end else if (!read_fire && resp_retire) begin
      outstanding <= outstanding - OUT_WIDTH'(1);
    end
  end

  pztb_mem_traffic_checker #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_checker (
    .clk                 (i_clk),
    .rst_n               (i_rst_n),
    .start               (start_accept),
    .base_address        (i_base_address),
    .seed                (seed),
    .resp_fire           (resp_fire),
    .spurious            (spurious),
    .resp_data           (i_resp_data),
    .error_count         (o_error_count)
`ifdef PZTB_MEM_TRAFFIC_FIRST_ERROR_EN
    ,
    .first_error_valid   (o_first_error_valid),
    .first_error_address (o_first_error_address),
    .first_error_data    (o_first_error_data)
`endif
  );

endmodule
